// File: rtl/sargantana_icache_refill_ctrl.sv
// Instruction-cache refill controller: one outstanding line refill, kill/flush handling.
// ICACHE_FLUSH_WALK_EN selects a per-set invalidation walk instead of a single invalidate-all pulse.
module sargantana_icache_refill_ctrl #(
  parameter int unsigned TAG_W  = 20,
  parameter int unsigned IDX_W  = 6,
  parameter int unsigned N_WAY  = 4,
  parameter int unsigned LINE_W = 128,
  parameter int unsigned WAY_W  = $clog2(N_WAY)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   cmp_enable_i,
  input  logic                   valid_ireq_i,
  input  logic                   miss_i,
  input  logic                   ireq_kill_i,
  input  logic                   flush_i,
  input  logic [TAG_W-1:0]       cline_tag_i,
  input  logic [IDX_W-1:0]       idx_i,
  input  logic [WAY_W-1:0]       way_to_replace_i,
  output logic                   mem_req_valid_o,
  input  logic                   mem_req_ready_i,
  output logic [TAG_W+IDX_W-1:0] mem_req_addr_o,
  input  logic                   mem_resp_valid_i,
  input  logic [LINE_W-1:0]      mem_resp_data_i,
  output logic                   line_we_o,
  output logic [WAY_W-1:0]       line_way_o,
  output logic [IDX_W-1:0]       line_idx_o,
  output logic [TAG_W-1:0]       line_tag_o,
  output logic [LINE_W-1:0]      line_data_o,
  output logic                   inval_valid_o,
  output logic [IDX_W-1:0]       inval_idx_o,
  output logic                   inval_all_o,
  output logic                   fill_done_o,
  output logic                   ifill_process_started_o,
  output logic                   busy_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT, S_WRITE, S_DRAIN, S_FLUSH
  } state_t;

  state_t           state_q, state_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WAY_W-1:0] way_q, way_d;
  logic             pend_q, pend_d;
`ifdef ICACHE_FLUSH_WALK_EN
  logic [IDX_W-1:0] cnt_q, cnt_d;
`endif

  always_comb begin
    state_d = state_q;
    tag_d   = tag_q;
    idx_d   = idx_q;
    way_d   = way_q;
    pend_d  = pend_q;
`ifdef ICACHE_FLUSH_WALK_EN
    cnt_d   = cnt_q;
`endif
    if (flush_i && state_q != S_IDLE && state_q != S_FLUSH) pend_d = 1'b1;
    case (state_q)
      S_IDLE: begin
        if (flush_i || pend_q) begin
          state_d = S_FLUSH;
        end else if (cmp_enable_i && valid_ireq_i && miss_i && !ireq_kill_i) begin
          tag_d   = cline_tag_i;
          idx_d   = idx_i;
          way_d   = way_to_replace_i;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        // An accepted request always owes a response, so kill/flush on the handshake drains it.
        if (mem_req_ready_i)  state_d = (ireq_kill_i || flush_i) ? S_DRAIN : S_WAIT;
        else if (ireq_kill_i) state_d = S_IDLE;
        else if (flush_i)     state_d = S_FLUSH;
      end
      S_WAIT: begin
        if (mem_resp_valid_i)             state_d = ireq_kill_i ? S_IDLE : S_WRITE;
        else if (ireq_kill_i || flush_i)  state_d = S_DRAIN;
      end
      S_WRITE: state_d = S_IDLE;
      S_DRAIN: if (mem_resp_valid_i) state_d = S_IDLE;
      S_FLUSH: begin
`ifdef ICACHE_FLUSH_WALK_EN
        if (cnt_q == '1) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`else
        state_d = S_IDLE;
`endif
      end
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_FLUSH && state_q != S_FLUSH) pend_d = 1'b0;
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q                 <= S_IDLE;
      tag_q                   <= '0;
      idx_q                   <= '0;
      way_q                   <= '0;
      pend_q                  <= 1'b0;
`ifdef ICACHE_FLUSH_WALK_EN
      cnt_q                   <= '0;
`endif
      mem_req_valid_o         <= 1'b0;
      mem_req_addr_o          <= '0;
      line_we_o               <= 1'b0;
      line_way_o              <= '0;
      line_idx_o              <= '0;
      line_tag_o              <= '0;
      line_data_o             <= '0;
      inval_valid_o           <= 1'b0;
      inval_idx_o             <= '0;
      inval_all_o             <= 1'b0;
      fill_done_o             <= 1'b0;
      ifill_process_started_o <= 1'b0;
      busy_o                  <= 1'b0;
    end else begin
      state_q                 <= state_d;
      tag_q                   <= tag_d;
      idx_q                   <= idx_d;
      way_q                   <= way_d;
      pend_q                  <= pend_d;
      mem_req_valid_o         <= (state_d == S_REQ);
      mem_req_addr_o          <= (state_d == S_REQ) ? {tag_d, idx_d} : '0;
      line_we_o               <= (state_d == S_WRITE);
      fill_done_o             <= (state_d == S_WRITE);
      line_way_o              <= (state_d == S_WRITE) ? way_d : '0;
      line_idx_o              <= (state_d == S_WRITE) ? idx_d : '0;
      line_tag_o              <= (state_d == S_WRITE) ? tag_d : '0;
      line_data_o             <= (state_d == S_WRITE) ? mem_resp_data_i : '0;
      ifill_process_started_o <= (state_d == S_REQ) || (state_d == S_WAIT) || (state_d == S_WRITE);
      busy_o                  <= (state_d != S_IDLE);
`ifdef ICACHE_FLUSH_WALK_EN
      cnt_q                   <= cnt_d;
      inval_valid_o           <= (state_d == S_FLUSH);
      inval_idx_o             <= (state_d == S_FLUSH) ? cnt_d : '0;
      inval_all_o             <= 1'b0;
`else
      inval_valid_o           <= 1'b0;
      inval_idx_o             <= '0;
      inval_all_o             <= (state_d == S_FLUSH);
`endif
    end
  end

endmodule

// File: tb/tb_sargantana_icache_refill_ctrl.sv
// Directed self-checking bench for sargantana_icache_refill_ctrl (both flush build variants).
module tb_sargantana_icache_refill_ctrl;
  localparam int TAG_W = 20, IDX_W = 6, N_WAY = 4, LINE_W = 128, WAY_W = 2;

  logic clk = 0, rst = 1;
  logic cmp_en = 0, vreq = 0, miss = 0, kill = 0, flush = 0;
  logic [TAG_W-1:0] tag = '0;
  logic [IDX_W-1:0] idx = '0;
  logic [WAY_W-1:0] way = '0;
  logic req_v, req_rdy = 0, resp_v = 0;
  logic [TAG_W+IDX_W-1:0] req_addr;
  logic [LINE_W-1:0] resp_data = '0, l_data;
  logic l_we, inv_v, inv_all, done, started, busy;
  logic [WAY_W-1:0] l_way;
  logic [IDX_W-1:0] l_idx, inv_idx;
  logic [TAG_W-1:0] l_tag;

  int total = 0, bad = 0;

  sargantana_icache_refill_ctrl #(.TAG_W(TAG_W), .IDX_W(IDX_W), .N_WAY(N_WAY), .LINE_W(LINE_W)) dut (
    .clk_i(clk), .rst_i(rst), .cmp_enable_i(cmp_en), .valid_ireq_i(vreq), .miss_i(miss),
    .ireq_kill_i(kill), .flush_i(flush), .cline_tag_i(tag), .idx_i(idx), .way_to_replace_i(way),
    .mem_req_valid_o(req_v), .mem_req_ready_i(req_rdy), .mem_req_addr_o(req_addr),
    .mem_resp_valid_i(resp_v), .mem_resp_data_i(resp_data), .line_we_o(l_we), .line_way_o(l_way),
    .line_idx_o(l_idx), .line_tag_o(l_tag), .line_data_o(l_data), .inval_valid_o(inv_v),
    .inval_idx_o(inv_idx), .inval_all_o(inv_all), .fill_done_o(done),
    .ifill_process_started_o(started), .busy_o(busy));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic issue_miss(input logic [TAG_W-1:0] t, input logic [IDX_W-1:0] i, input logic [WAY_W-1:0] w);
    cmp_en = 1; vreq = 1; miss = 1; tag = t; idx = i; way = w;
    tick();
    cmp_en = 0; vreq = 0; miss = 0;
  endtask

  function automatic logic [299:0] all_outs();
    return {req_v, req_addr, l_we, l_way, l_idx, l_tag, l_data, inv_v, inv_idx, inv_all, done, started, busy};
  endfunction

  task automatic test_reset();
    rst = 1; tick(); tick(); rst = 0;
    total++; if (all_outs() !== '0) begin bad++; $display("FAIL reset_outs got=%h exp=0", all_outs()); end
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_idle busy got=%b exp=0", busy); end
  endtask

  task automatic test_refill();
    logic [LINE_W-1:0] pat = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
    issue_miss(20'h12345, 6'd5, 2'd2);
    for (int c = 0; c < 2; c++) begin
      total++; if (req_v !== 1'b1 || req_addr !== {20'h12345, 6'd5})
        begin bad++; $display("FAIL refill_req c=%0d got v=%b a=%h exp v=1 a=%h", c, req_v, req_addr, {20'h12345, 6'd5}); end
      tick();
    end
    total++; if (req_v !== 1'b1 || busy !== 1'b1 || started !== 1'b1)
      begin bad++; $display("FAIL refill_req_hold got v=%b b=%b s=%b exp 1 1 1", req_v, busy, started); end
    req_rdy = 1; tick(); req_rdy = 0;
    for (int c = 0; c < 2; c++) begin
      total++; if (req_v !== 1'b0 || l_we !== 1'b0 || started !== 1'b1)
        begin bad++; $display("FAIL refill_wait c=%0d got v=%b we=%b s=%b exp 0 0 1", c, req_v, l_we, started); end
      tick();
    end
    resp_v = 1; resp_data = pat; tick(); resp_v = 0; resp_data = '0;
    total++; if (l_we !== 1'b1 || done !== 1'b1 || l_way !== 2'd2 || l_idx !== 6'd5 || l_tag !== 20'h12345)
      begin bad++; $display("FAIL refill_write got we=%b d=%b w=%0d i=%0d t=%h exp 1 1 2 5 12345", l_we, done, l_way, l_idx, l_tag); end
    total++; if (l_data !== pat) begin bad++; $display("FAIL refill_data got=%h exp=%h", l_data, pat); end
    // new miss offered during the fill_done cycle must wait a cycle
    cmp_en = 1; vreq = 1; miss = 1; tag = 20'hABCDE; idx = 6'd9; way = 2'd1;
    tick();
    total++; if (l_we !== 1'b0 || done !== 1'b0 || busy !== 1'b0 || req_v !== 1'b0)
      begin bad++; $display("FAIL b2b_hold got we=%b d=%b b=%b v=%b exp 0 0 0 0", l_we, done, busy, req_v); end
    tick(); cmp_en = 0; vreq = 0; miss = 0;
    total++; if (req_v !== 1'b1 || req_addr !== {20'hABCDE, 6'd9})
      begin bad++; $display("FAIL b2b_accept got v=%b a=%h exp v=1 a=%h", req_v, req_addr, {20'hABCDE, 6'd9}); end
    kill = 1; tick(); kill = 0;
  endtask

  task automatic test_kill_req();
    issue_miss(20'h00F0F, 6'd33, 2'd3);
    total++; if (req_v !== 1'b1) begin bad++; $display("FAIL killreq_pre got v=%b exp 1", req_v); end
    kill = 1; tick(); kill = 0;
    total++; if (busy !== 1'b0 || req_v !== 1'b0 || started !== 1'b0)
      begin bad++; $display("FAIL killreq_idle got b=%b v=%b s=%b exp 0 0 0", busy, req_v, started); end
    for (int c = 0; c < 3; c++) begin
      tick();
      total++; if (l_we !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL killreq_nowrite c=%0d we=%b b=%b exp 0 0", c, l_we, busy); end
    end
  endtask

  task automatic test_kill_wait();
    issue_miss(20'h55555, 6'd12, 2'd0);
    req_rdy = 1; tick(); req_rdy = 0;
    kill = 1; tick(); kill = 0;
    total++; if (busy !== 1'b1 || started !== 1'b0 || req_v !== 1'b0)
      begin bad++; $display("FAIL killwait_drain got b=%b s=%b v=%b exp 1 0 0", busy, started, req_v); end
    for (int c = 0; c < 3; c++) begin
      tick();
      total++; if (l_we !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL killwait_hold c=%0d we=%b b=%b exp 0 1", c, l_we, busy); end
    end
    resp_v = 1; resp_data = '1; tick(); resp_v = 0; resp_data = '0;
    total++; if (busy !== 1'b0 || l_we !== 1'b0 || done !== 1'b0)
      begin bad++; $display("FAIL killwait_done got b=%b we=%b d=%b exp 0 0 0", busy, l_we, done); end
  endtask

  task automatic test_flush_wait();
    issue_miss(20'h0BEEF, 6'd7, 2'd1);
    req_rdy = 1; tick(); req_rdy = 0;
    flush = 1; tick(); flush = 0;
    total++; if (busy !== 1'b1 || started !== 1'b0 || inv_v !== 1'b0 || inv_all !== 1'b0)
      begin bad++; $display("FAIL flush_drain got b=%b s=%b iv=%b ia=%b exp 1 0 0 0", busy, started, inv_v, inv_all); end
    tick();
    resp_v = 1; tick(); resp_v = 0;
    total++; if (l_we !== 1'b0 || busy !== 1'b0)
      begin bad++; $display("FAIL flush_postdrain got we=%b b=%b exp 0 0", l_we, busy); end
    tick();
`ifdef ICACHE_FLUSH_WALK_EN
    for (int i = 0; i < 64; i++) begin
      total++; if (inv_v !== 1'b1 || inv_idx !== 6'(i) || inv_all !== 1'b0 || busy !== 1'b1)
        begin bad++; $display("FAIL flush_walk i=%0d got iv=%b idx=%0d ia=%b b=%b exp 1 %0d 0 1", i, inv_v, inv_idx, inv_all, busy, i); end
      flush = (i == 10);
      tick();
    end
    flush = 0;
`else
    total++; if (inv_all !== 1'b1 || inv_v !== 1'b0 || busy !== 1'b1)
      begin bad++; $display("FAIL flush_all got ia=%b iv=%b b=%b exp 1 0 1", inv_all, inv_v, busy); end
    flush = 1; tick(); flush = 0;
`endif
    total++; if (inv_all !== 1'b0 || inv_v !== 1'b0 || busy !== 1'b0)
      begin bad++; $display("FAIL flush_end got ia=%b iv=%b b=%b exp 0 0 0", inv_all, inv_v, busy); end
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL flush_merged got b=%b exp 0", busy); end
  endtask

  task automatic test_reset_mid();
    logic [LINE_W-1:0] pat = 128'h11112222_33334444_55556666_77778888;
    issue_miss(20'h77777, 6'd40, 2'd3);
    req_rdy = 1; tick(); req_rdy = 0;
    rst = 1; tick(); rst = 0;
    total++; if (all_outs() !== '0) begin bad++; $display("FAIL rstmid_outs got=%h exp=0", all_outs()); end
    issue_miss(20'h3C3C3, 6'd63, 2'd1);
    total++; if (req_v !== 1'b1 || req_addr !== {20'h3C3C3, 6'd63})
      begin bad++; $display("FAIL rstmid_req got v=%b a=%h exp v=1 a=%h", req_v, req_addr, {20'h3C3C3, 6'd63}); end
    req_rdy = 1; tick(); req_rdy = 0;
    resp_v = 1; resp_data = pat; tick(); resp_v = 0; resp_data = '0;
    total++; if (l_we !== 1'b1 || done !== 1'b1 || l_way !== 2'd1 || l_idx !== 6'd63 || l_tag !== 20'h3C3C3 || l_data !== pat)
      begin bad++; $display("FAIL rstmid_write got we=%b d=%b w=%0d i=%0d t=%h data=%h", l_we, done, l_way, l_idx, l_tag, l_data); end
    tick();
    total++; if (l_we !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rstmid_idle got we=%b b=%b exp 0 0", l_we, busy); end
  endtask

  initial begin
    test_reset();
    test_refill();
    test_kill_req();
    test_kill_wait();
    test_flush_wait();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
